// File: rtl/jt1943_prom_loader.sv
// Colour-mixer PROM programming port: picks the 1 KiB PROM window out of the ROM download
// stream and writes each nibble to 12A/13A/14A/12C through a SETUP/STROBE/HOLD sequence.
module jt1943_prom_loader #(
  parameter int             AW        = 22,
  parameter logic [AW-1:0]  PROM_BASE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          dl_valid,
  output logic          dl_ready,
  output logic [7:0]    prog_addr,
  output logic [3:0]    prom_din,
  output logic          prom_12a_we,
  output logic          prom_13a_we,
  output logic          prom_14a_we,
  output logic          prom_12c_we,
  output logic          prom_done
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t        state_q;
  logic          idle_q;
  logic          dl_q;
  logic          clr_pend_q;
  logic [1:0]    sel_q;
  logic [3:0]    we_q;
  logic [10:0]   cnt_q;
  logic          done_q;
  logic [7:0]    addr_q;
  logic [3:0]    din_q;

  logic [AW-1:0] off;
  logic          in_win;
  logic          accept;
  logic          rise;
  logic [10:0]   cnt_d;
  logic          unused_hi;

  // Wrap-around subtraction plus the compare rejects addresses below the base as well.
  assign off       = dl_addr - PROM_BASE;
  assign in_win    = (dl_addr >= PROM_BASE) && (off[AW-1:10] == '0);
  assign dl_ready  = idle_q & downloading;
  assign accept    = dl_valid & dl_ready;
  assign rise      = downloading & ~dl_q;
  assign cnt_d     = (cnt_q == 11'd1024) ? cnt_q : cnt_q + 11'd1;
  assign unused_hi = ^dl_data[7:4];

  assign prog_addr   = addr_q;
  assign prom_din    = din_q;
  assign prom_12a_we = we_q[0];
  assign prom_13a_we = we_q[1];
  assign prom_14a_we = we_q[2];
  assign prom_12c_we = we_q[3];
  assign prom_done   = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idle_q     <= 1'b0;
      dl_q       <= 1'b0;
      clr_pend_q <= 1'b0;
      sel_q      <= 2'd0;
      we_q       <= 4'd0;
      cnt_q      <= 11'd0;
      done_q     <= 1'b0;
      addr_q     <= 8'd0;
      din_q      <= 4'd0;
    end else begin
      dl_q <= downloading;
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            cnt_q  <= 11'd0;
            done_q <= 1'b0;
          end
          if (accept && in_win) begin
            state_q <= S_SETUP;
            idle_q  <= 1'b0;
            sel_q   <= off[9:8];
            addr_q  <= off[7:0];
            din_q   <= dl_data[3:0];
          end else begin
            idle_q <= 1'b1;
          end
        end
        S_SETUP: begin
          we_q    <= 4'b0001 << sel_q;
          state_q <= S_STROBE;
          if (rise) clr_pend_q <= 1'b1;
        end
        S_STROBE: begin
          we_q    <= 4'd0;
          state_q <= S_HOLD;
          if (rise) clr_pend_q <= 1'b1;
        end
        S_HOLD: begin
          state_q <= S_IDLE;
          idle_q  <= 1'b1;
          // A session that started mid-write wipes the count instead of including this write.
          if (rise || clr_pend_q) begin
            cnt_q      <= 11'd0;
            done_q     <= 1'b0;
            clr_pend_q <= 1'b0;
          end else begin
            cnt_q  <= cnt_d;
            done_q <= (cnt_d == 11'd1024);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt1943_prom_loader.sv
// Scoreboard bench for jt1943_prom_loader: writes are predicted from the download address
// arithmetic and matched against strobes by an independent monitor.
module tb_jt1943_prom_loader;

  localparam logic [21:0] BASE = 22'h1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [21:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_valid = 1'b0;
  logic        dl_ready;
  logic [7:0]  prog_addr;
  logic [3:0]  prom_din;
  logic        prom_12a_we, prom_13a_we, prom_14a_we, prom_12c_we;
  logic        prom_done;

  jt1943_prom_loader #(.AW(22), .PROM_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_valid(dl_valid), .dl_ready(dl_ready),
    .prog_addr(prog_addr), .prom_din(prom_din),
    .prom_12a_we(prom_12a_we), .prom_13a_we(prom_13a_we),
    .prom_14a_we(prom_14a_we), .prom_12c_we(prom_12c_we),
    .prom_done(prom_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] we; logic [7:0] addr; logic [3:0] din; } wr_t;
  wr_t  expq[$];
  int   nvec = 0;
  int   nmis = 0;
  int   mcount = 0;
  int   cyc = 0;
  int   last_acc = 0;
  logic [3:0] we_bus;
  logic [3:0] prev_we = 4'd0;

  assign we_bus = {prom_12c_we, prom_14a_we, prom_13a_we, prom_12a_we};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Monitor: every strobe must be a single-cycle pulse matching the oldest predicted write.
  wr_t e;
  always @(negedge clk) begin
    if (rst_n && we_bus != 4'd0) begin
      check("strobe_width", 32'(prev_we), 32'd0);
      if (expq.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_strobe: got we=%b required none", we_bus);
      end else begin
        e = expq.pop_front();
        check("we_select", 32'(we_bus), 32'(e.we));
        check("prog_addr", 32'(prog_addr), 32'(e.addr));
        check("prom_din", 32'(prom_din), 32'(e.din));
      end
    end
    prev_we <= rst_n ? we_bus : 4'd0;
  end

  task automatic send(input logic [21:0] a, input logic [7:0] d, input bit track);
    int o;
    bit ok;
    o  = int'(a) - int'(BASE);
    ok = 1'b0;
    dl_addr  = a;
    dl_data  = d;
    dl_valid = 1'b1;
    for (int t = 0; t < 32; t++) begin
      #1;
      if (dl_ready) begin
        ok = 1'b1;
        @(posedge clk);
        last_acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      nvec++;
      nmis++;
      $display("FAIL accept_timeout: addr %h not accepted, required within 32 clk", a);
      dl_valid = 1'b0;
      @(negedge clk);
    end else begin
      if (o >= 0 && o < 1024) begin
        if (track) expq.push_back('{we: 4'(1 << (o / 256)), addr: 8'(o % 256), din: d[3:0]});
        if (mcount < 1024) mcount++;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    dl_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_done(input string nm);
    check(nm, 32'(prom_done), 32'(mcount == 1024));
  endtask

  task automatic load_all();
    for (int o = 0; o < 1024; o++) send(22'(int'(BASE) + o), 8'($urandom), 1'b1);
    dl_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("done_during_last_hold", 32'(prom_done), 32'd0);
    @(negedge clk);
    check("done_after_last_hold", 32'(prom_done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, o;
    // Reset values
    downloading = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(dl_ready), 32'd0);
    check("rst_we", 32'(we_bus), 32'd0);
    check("rst_addr", 32'(prog_addr), 32'd0);
    check("rst_din", 32'(prom_din), 32'd0);
    check("rst_done", 32'(prom_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(dl_ready), 32'd1);

    // Single write with stage timing
    send(BASE + 22'h105, 8'hA7, 1'b1);
    dl_valid = 1'b0;
    check("setup_ready", 32'(dl_ready), 32'd0);
    check("setup_addr", 32'(prog_addr), 32'h05);
    check("setup_din", 32'(prom_din), 32'h7);
    check("setup_we", 32'(we_bus), 32'd0);
    @(negedge clk);
    check("strobe_13a", 32'(we_bus), 32'b0010);
    check("strobe_ready", 32'(dl_ready), 32'd0);
    @(negedge clk);
    check("hold_we", 32'(we_bus), 32'd0);
    check("hold_ready", 32'(dl_ready), 32'd0);
    @(negedge clk);
    check("ready_back", 32'(dl_ready), 32'd1);

    // Out-of-window bytes are swallowed
    send(22'h0FFF, 8'($urandom), 1'b1);
    dl_valid = 1'b0;
    check("oow_low_ready", 32'(dl_ready), 32'd1);
    check("oow_low_addr", 32'(prog_addr), 32'h05);
    send(22'h1400, 8'($urandom), 1'b1);
    dl_valid = 1'b0;
    check("oow_high_ready", 32'(dl_ready), 32'd1);
    check("oow_high_addr", 32'(prog_addr), 32'h05);
    check("oow_high_din", 32'(prom_din), 32'h7);

    // Back-to-back duplicate address
    send(BASE + 22'h3FF, 8'h5E, 1'b1);
    t0 = last_acc;
    send(BASE + 22'h3FF, 8'h91, 1'b1);
    check("b2b_spacing", 32'(last_acc - t0), 32'd4);
    idle(4);

    // New session, full window load
    downloading = 1'b0;
    idle(2);
    downloading = 1'b1;
    mcount = 0;
    @(negedge clk);
    load_all();

    // Random addresses around the window, random gaps; counter saturates
    for (int i = 0; i < 40; i++) begin
      o = int'($urandom_range(0, 1200)) - 100;
      send(22'(int'(BASE) + o), 8'($urandom), 1'b1);
      idle(int'($urandom_range(0, 3)));
    end
    idle(4);
    check_done("done_saturated");

    // Session end keeps prom_done; next session clears it
    downloading = 1'b0;
    idle(5);
    check_done("done_holds");
    check("ready_not_dl", 32'(dl_ready), 32'd0);
    downloading = 1'b1;
    idle(2);
    mcount = 0;
    check_done("done_cleared_rise");
    load_all();

    // Session restart while a write is in flight: write completes, count restarts from zero
    send(BASE + 22'h0AA, 8'h6B, 1'b1);
    dl_valid = 1'b0;
    downloading = 1'b0;
    @(negedge clk);
    downloading = 1'b1;
    idle(4);
    mcount = 0;
    check_done("done_cleared_inflight");
    for (int k = 0; k < 1023; k++) send(22'(int'(BASE) + k), 8'($urandom), 1'b1);
    idle(4);
    check_done("done_at_1023");
    send(BASE + 22'h3FF, 8'($urandom), 1'b1);
    idle(4);
    check_done("done_at_1024");

    // Asynchronous reset during STROBE
    send(BASE + 22'h2AB, 8'h3C, 1'b0);
    dl_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    mcount = 0;
    check("midrst_we", 32'(we_bus), 32'd0);
    check_done("midrst_done");
    check("midrst_ready", 32'(dl_ready), 32'd0);
    check("midrst_addr", 32'(prog_addr), 32'd0);
    repeat (2) @(negedge clk);
    check("inrst_ready", 32'(dl_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_ready", 32'(dl_ready), 32'd1);
    idle(4);
    check("pending_writes", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
